// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit with architectural HI/LO.
// A MULT/MULTU/DIV/DIVU in EX freezes IF..EX while the unit is busy.
// The result is written to HI/LO on the edge where the counter expires.
// The unit then holds in DONE for one cycle, or longer while ex_hold is
// high, so that the same instruction is not launched again.
// All state changes on the falling clock edge, matching the pipeline registers.
module ex_muldiv #(
  parameter int MUL_CYCLES = 2,   // busy cycles for MULT/MULTU (1..8)
  parameter int DIV_CYCLES = 32   // busy cycles for DIV/DIVU (one quotient bit each)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  idex_md_op,
  input  logic [31:0] idex_op_A,
  input  logic [31:0] idex_op_B,
  input  logic        cu_flush,
  input  logic        ex_hold,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo,
  output logic        md_stall,
  output logic        md_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;        // raw rs operand of the in-flight op
  logic [31:0] b_q, b_d;        // raw rt operand of the in-flight op
  logic [31:0] quo_q, quo_d;    // dividend shifting out / quotient shifting in
  logic [31:0] rem_q, rem_d;    // partial remainder (magnitude)
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        stall_c;

  // Datapath helpers
  logic        in_long, in_div;
  logic [31:0] a_abs_in;
  logic        div_signed;
  logic [31:0] divisor_mag;
  logic [32:0] rem_shift, rem_sub;
  logic        rem_ge;
  logic [31:0] rem_step, quo_step;
  logic        quo_neg, rem_neg;
  logic [31:0] div_lo, div_hi;
  logic [63:0] prod_s, prod_u, prod;

  // Operand decode, one restoring-division step and the multiplier
  always_comb begin
    in_long  = (idex_md_op == OP_MULT) || (idex_md_op == OP_MULTU) ||
               (idex_md_op == OP_DIV)  || (idex_md_op == OP_DIVU);
    in_div   = (idex_md_op == OP_DIV)  || (idex_md_op == OP_DIVU);
    // Signed division works on magnitudes; the signs are restored at the end.
    a_abs_in = ((idex_md_op == OP_DIV) && idex_op_A[31]) ? (~idex_op_A + 32'd1) : idex_op_A;

    div_signed  = (op_q == OP_DIV);
    divisor_mag = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;

    rem_shift = {rem_q, quo_q[31]};
    rem_sub   = rem_shift - {1'b0, divisor_mag};
    rem_ge    = (rem_shift >= {1'b0, divisor_mag});
    rem_step  = rem_ge ? rem_sub[31:0] : rem_shift[31:0];
    quo_step  = {quo_q[30:0], rem_ge};

    // A zero divisor leaves all-ones in the quotient and |A| in the remainder.
    // Restoring the dividend sign on the remainder returns op_A unchanged.
    quo_neg = div_signed && (a_q[31] ^ b_q[31]);
    rem_neg = div_signed && a_q[31];
    if (b_q == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
    end else begin
      div_lo = quo_neg ? (~quo_step + 32'd1) : quo_step;
    end
    div_hi = rem_neg ? (~rem_step + 32'd1) : rem_step;

    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod   = (op_q == OP_MULT) ? prod_s : prod_u;
  end

  // Next-state, register-update and stall logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_c = 1'b0;

    if (cu_flush) begin
      // A flush kills the EX instruction; HI/LO keep their prior values.
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_long) begin
            stall_c = 1'b1;
            op_d    = idex_md_op;
            a_d     = idex_op_A;
            b_d     = idex_op_B;
            quo_d   = a_abs_in;
            rem_d   = 32'd0;
            cnt_d   = in_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
            state_d = S_BUSY;
          end else if (!ex_hold) begin
            if (idex_md_op == OP_MTHI) hi_d = idex_op_A;
            if (idex_md_op == OP_MTLO) lo_d = idex_op_A;
          end
        end
        S_BUSY: begin
          // Counting continues even while ex_hold is high.
          stall_c = 1'b1;
          if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            quo_d = quo_step;
            rem_d = rem_step;
          end
          if (cnt_q <= 6'd1) begin
            cnt_d   = 6'd0;
            state_d = S_DONE;
            if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
              hi_d = div_hi;
              lo_d = div_lo;
            end else begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        S_DONE: begin
          // The finished instruction is still in EX; ignore its op here.
          if (!ex_hold) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_BUSY);
  end

  // State registers, falling-edge; reset aborts any operation
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign md_hi    = hi_q;
  assign md_lo    = lo_q;
  assign md_busy  = busy_q;
  assign md_stall = stall_c && !reset;

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: scoreboard of expected HI/LO/stall per operation.
module tb_ex_muldiv;

  logic        clk = 1'b1;
  logic        reset;
  logic [3:0]  idex_md_op;
  logic [31:0] idex_op_A;
  logic [31:0] idex_op_B;
  logic        cu_flush;
  logic        ex_hold;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_stall;
  logic        md_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } exp_t;

  exp_t sb_q[$];

  ex_muldiv #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .idex_md_op (idex_md_op),
    .idex_op_A  (idex_op_A),
    .idex_op_B  (idex_op_B),
    .cu_flush   (cu_flush),
    .ex_hold    (ex_hold),
    .md_hi      (md_hi),
    .md_lo      (md_lo),
    .md_stall   (md_stall),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  // One cycle: sample the combinational stall mid-cycle, then settle after the falling edge.
  task automatic tick(output logic s);
    @(posedge clk);
    s = md_stall;
    @(negedge clk);
    #1;
  endtask

  // Reference model built from language arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.hi = 32'd0; e.lo = 32'd0; e.stall = 0;
    case (op)
      4'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.stall = 3; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.stall = 3; end
      4'd3: begin
        e.stall = 33;
        if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
        else begin
          q = sa / sb; r = sa % sb;
          qv = q; rv = r;
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end
      end
      4'd4: begin
        e.stall = 33;
        if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one long op, run until the DONE cycle, compare against the scoreboard.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int estall);
    exp_t e;
    logic s;
    int   n;
    bit   done;
    e.hi = ehi; e.lo = elo; e.stall = estall;
    sb_q.push_back(e);
    idex_md_op = op; idex_op_A = a; idex_op_B = b;
    n = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick(s);
      if (s) n++;
      else done = 1;
    end
    idex_md_op = 4'd0;
    e = sb_q.pop_front();
    checks++;
    if (!done) begin errors++; $display("FAIL op_timeout op=%0d actual=no_done required=done", op); end
    checks++;
    if (n !== e.stall) begin errors++; $display("FAIL stall_cycles op=%0d actual=%0d required=%0d", op, n, e.stall); end
    checks++;
    if ({md_hi, md_lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL hilo op=%0d a=%h b=%h actual=%h_%h required=%h_%h", op, a, b, md_hi, md_lo, e.hi, e.lo);
    end
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL busy_after op=%0d actual=%b required=0", op, md_busy); end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h stall=%0d", op, a, b, md_hi, md_lo, n);
  endtask

  task automatic test_reset();
    logic s;
    reset = 1'b1; cu_flush = 1'b0; ex_hold = 1'b0;
    idex_md_op = 4'd1; idex_op_A = 32'd3; idex_op_B = 32'd4;
    tick(s);
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL reset_stall actual=%b required=0", s); end
    tick(s);
    reset = 1'b0; idex_md_op = 4'd0;
    checks++;
    if ({md_hi, md_lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo actual=%h_%h required=0", md_hi, md_lo); end
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", md_busy); end
    tick(s);
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL idle_stall actual=%b required=0", s); end
    $display("reset: hi=%h lo=%h busy=%b", md_hi, md_lo, md_busy);
  endtask

  task automatic test_mult();
    exp_t e;
    logic [31:0] a, b;
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 3);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      e = model(4'd1 + 4'(i % 2), a, b);
      run_op(4'd1 + 4'(i % 2), a, b, e.hi, e.lo, e.stall);
    end
  endtask

  task automatic test_div();
    exp_t e;
    logic [31:0] a, b;
    run_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run_op(4'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
    run_op(4'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 1) b = ~b + 32'd1;
      e = model(4'd3 + 4'(i % 2), a, b);
      run_op(4'd3 + 4'(i % 2), a, b, e.hi, e.lo, e.stall);
    end
  endtask

  task automatic test_flush();
    logic s;
    int n;
    idex_md_op = 4'd5; idex_op_A = 32'hAAAA_0001; tick(s);
    idex_md_op = 4'd6; idex_op_A = 32'h5555_0002; tick(s);
    idex_md_op = 4'd0;
    checks++;
    if ({md_hi, md_lo} !== {32'hAAAA_0001, 32'h5555_0002}) begin
      errors++; $display("FAIL mthi_mtlo actual=%h_%h required=aaaa0001_55550002", md_hi, md_lo);
    end
    idex_md_op = 4'd3; idex_op_A = 32'd1000; idex_op_B = 32'd3;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(s); if (s) n++; end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL flush_prestall actual=%0d required=10", n); end
    cu_flush = 1'b1;
    tick(s);
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL flush_stall actual=%b required=0", s); end
    cu_flush = 1'b0; idex_md_op = 4'd0;
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_busy actual=%b required=0", md_busy); end
    checks++;
    if ({md_hi, md_lo} !== {32'hAAAA_0001, 32'h5555_0002}) begin
      errors++; $display("FAIL flush_hilo actual=%h_%h required=aaaa0001_55550002", md_hi, md_lo);
    end
    tick(s);
    checks++;
    if (s !== 1'b0 || md_busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle actual=stall%b_busy%b required=stall0_busy0", s, md_busy);
    end
    $display("flush: hi=%h lo=%h busy=%b", md_hi, md_lo, md_busy);
  endtask

  task automatic test_hold_done();
    logic s;
    int n;
    exp_t e;
    e.hi = 32'd0; e.lo = 32'd42; e.stall = 3;
    sb_q.push_back(e);
    ex_hold = 1'b1;
    idex_md_op = 4'd1; idex_op_A = 32'd7; idex_op_B = 32'd6;
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(s); if (s) n++; end
    e = sb_q.pop_front();
    checks++;
    if (n !== e.stall) begin errors++; $display("FAIL hold_stall actual=%0d required=%0d", n, e.stall); end
    for (int i = 0; i < 3; i++) begin
      tick(s);
      checks++;
      if (s !== 1'b0 || md_busy !== 1'b0) begin
        errors++; $display("FAIL done_hold_relaunch cyc=%0d actual=stall%b_busy%b required=stall0_busy0", i, s, md_busy);
      end
      checks++;
      if ({md_hi, md_lo} !== {e.hi, e.lo}) begin
        errors++; $display("FAIL done_hold_hilo cyc=%0d actual=%h_%h required=%h_%h", i, md_hi, md_lo, e.hi, e.lo);
      end
    end
    ex_hold = 1'b0;
    tick(s);
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL done_exit_stall actual=%b required=0", s); end
    idex_md_op = 4'd6; idex_op_A = 32'h0000_1234;
    tick(s);
    idex_md_op = 4'd0;
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL mtlo_stall actual=%b required=0", s); end
    checks++;
    if ({md_hi, md_lo} !== {32'd0, 32'h0000_1234}) begin
      errors++; $display("FAIL mtlo_value actual=%h_%h required=00000000_00001234", md_hi, md_lo);
    end
    $display("hold_done: hi=%h lo=%h", md_hi, md_lo);
  endtask

  task automatic test_reset_busy();
    logic s;
    idex_md_op = 4'd5; idex_op_A = 32'h11; tick(s);
    idex_md_op = 4'd6; idex_op_A = 32'h22; tick(s);
    idex_md_op = 4'd2; idex_op_A = 32'hFFFF_FFFF; idex_op_B = 32'hFFFF_FFFF;
    tick(s); tick(s);
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL busy_flag actual=%b required=1", md_busy); end
    reset = 1'b1; cu_flush = 1'b1;
    tick(s);
    reset = 1'b0; cu_flush = 1'b0; idex_md_op = 4'd0;
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL rst_busy_stall actual=%b required=0", s); end
    checks++;
    if ({md_hi, md_lo} !== 64'd0 || md_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy_state actual=%h_%h_busy%b required=0_0_busy0", md_hi, md_lo, md_busy);
    end
    $display("reset_busy: hi=%h lo=%h busy=%b", md_hi, md_lo, md_busy);
  endtask

  task automatic test_back_to_back();
    logic s;
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3);
    idex_md_op = 4'd5; idex_op_A = 32'hDEAD_BEEF;
    tick(s);
    idex_md_op = 4'd0;
    checks++;
    if (s !== 1'b0 || {md_hi, md_lo} !== {32'hDEAD_BEEF, 32'd0}) begin
      errors++; $display("FAIL b2b_mthi actual=stall%b_%h_%h required=stall0_deadbeef_00000000", s, md_hi, md_lo);
    end
    $display("back_to_back: hi=%h lo=%h", md_hi, md_lo);
  endtask

  initial begin
    reset = 1'b1; cu_flush = 1'b0; ex_hold = 1'b0;
    idex_md_op = 4'd0; idex_op_A = 32'd0; idex_op_B = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_hold_done();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter MUL_CYCLES, default 2, meaning busy cycles for MULT/MULTU (range 1..8).
REQ-002 Parameter DIV_CYCLES, default 32, meaning busy cycles for DIV/DIVU (fixed 32; one quotient bit per cycle).
REQ-003 clk  input  1  clock; all state updates on falling edge (same edge as pipeline registers).
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 idex_md_op  input  4  operation from ID/EX register: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others NOP.
REQ-006 idex_op_A  input  32  rs operand after forwarding.
REQ-007 idex_op_B  input  32  rt operand after forwarding.
REQ-008 cu_flush  input  1  exception/eret flush of EX instruction.
REQ-009 ex_hold  input  1  pipeline frozen by another stall source; EX instruction does not advance.
REQ-010 md_hi  output  32  architectural HI register.
REQ-011 md_lo  output  32  architectural LO register.
REQ-012 md_stall  output  1  combinational request to freeze IF..EX.
REQ-013 md_busy  output  1  registered; high while state is BUSY.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; state, counter, operand, HI, LO registers update only on falling clk edge.
REQ-015 IDLE with op 1-4 and !cu_flush: md_stall SHALL be 1 that cycle; at edge capture operands/op, load counter (MUL_CYCLES or 32), go BUSY.
REQ-016 BUSY: md_stall SHALL be 1; counter decrements each edge; on edge where counter reaches 0, write HI/LO and go DONE.
REQ-017 DONE: md_stall SHALL be 0; go IDLE on next edge if !ex_hold, else stay DONE; op inputs ignored in DONE (no relaunch).
REQ-018 MULT: {HI,LO} SHALL equal signed 32x32 -> 64 product; MULTU unsigned product.
REQ-019 DIVU: LO quotient, HI remainder, restoring algorithm, one bit per cycle.
REQ-020 DIV: operate on magnitudes; quotient truncated toward zero; remainder sign equals dividend sign.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divisor 0: full latency still; DIVU gives LO=0xFFFFFFFF, HI=op_A; DIV gives LO=0xFFFFFFFF, HI=op_A.
REQ-023 MTHI/MTLO in IDLE: write op_A to HI/LO at edge when !cu_flush && !ex_hold; no stall, no state change.
REQ-024 cu_flush in any state SHALL force IDLE at next edge with HI/LO unchanged; md_stall SHALL be 0 in any cycle cu_flush is 1.
REQ-025 md_hi/md_lo SHALL be register outputs only (MFHI/MFLO read them directly; no bypass of in-flight results).
REQ-026 ex_hold SHALL not pause BUSY counting.

Reset
REQ-027 reset at edge SHALL set state IDLE, counter 0, HI=0, LO=0, md_busy=0; md_stall reads 0 while reset high.
REQ-028 reset mid-BUSY SHALL abort the operation with no HI/LO write; reset has priority over cu_flush and all ops.

Verification
REQ-029 MULT 0xFFFFFFFE x 3 -> stall 3 cycles (issue + 2 BUSY), HI=0xFFFFFFFF, LO=0xFFFFFFFA, then DONE cycle with stall=0.
REQ-030 DIVU 100/7 -> stall 33 cycles, LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 DIV 0x80000000/-1 -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-032 cu_flush at BUSY cycle 10 of DIV -> IDLE next edge, HI/LO keep prior values, stall 0.
REQ-033 DONE with ex_hold=1 for 3 cycles, op still MULT -> no relaunch, HI/LO stable; then back-to-back MTLO 0x1234 -> LO=0x1234 with no stall.
REQ-034 reset asserted during BUSY MULTU -> HI=LO=0, md_busy=0 after edge.
